mips_data_mem: RTL
==================

// Module: mips_data_mem
// PURPOSE
//  Data-memory responder on the far end of the MIPS core's data port: accepts address/read-write/store-data
//  from the core's memory stage and returns load data one clock later, in time for the core's writeback mux.
//  Holds a word array, zero-fills it after reset, accepts a backdoor load stream for program/data images,
//  flags illegal stores and counts committed CPU stores. Sits beside the core in the top-level SoC.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address mapped to word 0; must be DEPTH*4-aligned
//  DEPTH       1024           number of 32-bit words (power of two, 16..65536)
//  CLEAR_INIT  1              1: zero-fill array after reset; 0: skip straight to SERVE
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  reset       in   1   asynchronous, active-high; one clock, async assert
//  addr        in   32  byte address from core (core's data_addr)
//  data_rd_wr  in   1   1 = read, 0 = write (core's data_rd_wr)
//  wr_data     in   32  store data from core (core's data_out)
//  rd_data     out  32  load data to core (core's data_in), registered
//  mem_ready   out  1   1 once zero-fill complete; system holds core in reset until set
//  load_valid  in   1   backdoor write request
//  load_ready  out  1   backdoor request accepted this cycle when valid&ready
//  load_addr   in   32  backdoor byte address (same map as addr)
//  load_data   in   32  backdoor word
//  err         out  1   sticky illegal-store flag
//  st_count    out  16  committed CPU stores, saturating
// BEHAVIOUR
//  Reset values: rd_data=0, mem_ready=0, load_ready=0, err=0, st_count=0, state=CLEAR (SERVE if CLEAR_INIT=0).
//  Index: idx = (addr-BASE_ADDR)>>2; in-range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH; addr[1:0] ignored for reads.
//  FSM CLEAR: clr_cnt from 0, writes 0 to mem[clr_cnt] each cycle; after word DEPTH-1 -> SERVE (DEPTH cycles total).
//   In CLEAR: CPU writes dropped (no err, no count), rd_data held 0, load_ready=0.
//  FSM SERVE: mem_ready=1. Only exit is reset; reset mid-CLEAR restarts clear at word 0.
//  Read (SERVE, data_rd_wr=1): rd_data <= mem[idx] at next edge (latency 1); out-of-range -> rd_data <= 0, no err
//   (core drives addr every cycle, so stray reads are legal). Read-first: same-edge write to idx is not forwarded.
//  CPU write (SERVE, data_rd_wr=0): legal iff in-range and addr[1:0]==0 -> mem[idx] <= wr_data,
//   st_count <= st_count+1 unless 16'hFFFF; rd_data holds previous value. Illegal -> no write, err <= 1 (sticky).
//  Backdoor: load_ready = (state==SERVE) & data_rd_wr; CPU write always wins the single write port.
//   Accepted load: in-range -> mem[load idx] <= load_data; out-of-range/misaligned -> silently dropped, no err.
//   Load writes never touch st_count. Load and CPU read same cycle: both proceed; read returns old word.
//  err cleared only by reset. No X on any output after reset release.
// STRUCTURE
//  Package mips_mem_pkg: MEM_READ=1'b1 / MEM_WRITE=1'b0, mem_state_t enum {CLEAR, SERVE}, WORD_BYTES=4,
//   shared with the core's opcode enums.
//  Sub-module dmem_array (DEPTH x 32, one write port, one registered read port, read-first); FSM, address
//   decode, write-port mux (CLEAR > CPU > load), err and st_count live in mips_data_mem.
// TESTING
//  1 Reset release, DEPTH=16 -> mem_ready=0 for 16 cycles, rises cycle 17; reads of 0x0..0x3C return 0.
//  2 Write 0xCAFE_F00D @0x8, next cycle read 0x8 -> rd_data=0xCAFE_F00D one edge after addr; st_count=1.
//  3 Store to 0x6 (misaligned) and to BASE_ADDR+4*DEPTH -> err=1, mem unchanged, st_count unchanged.
//  4 load_valid @0x4 data 0x1234 with CPU write @0xC same cycle -> load_ready=0, CPU write lands; next cycle load accepted.
//  5 Assert reset at clear cycle 5 -> all outputs to reset values; clear restarts, mem_ready after full DEPTH cycles.
//  6 65537 legal stores -> st_count saturates at 16'hFFFF; read-first check: load @0x10 + read 0x10 same edge returns old.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the MIPS data-memory path.
package mips_mem_pkg;

   localparam logic MEM_READ  = 1'b1;
   localparam logic MEM_WRITE = 1'b0;

   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      SERVE = 1'b1
   } mem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word array with one write port and one registered, read-first read port.
module dmem_array #(
   parameter int unsigned DEPTH = 1024,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          rd_en_i,
   input  logic          rd_zero_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rd_data_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rd_data_q;

   // Storage write; contents are initialised by the owner's clear sweep, not by reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read: returns the pre-write word when read and write hit the same index.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= rd_zero_i ? 32'h0 : mem_q[raddr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mips_data_mem.sv
// Data-memory responder for the MIPS core: clear sweep, CPU load/store, backdoor image loads.
module mips_data_mem
   import mips_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned DEPTH      = 1024,
   parameter bit          CLEAR_INIT = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] addr_i,
   input  logic        data_rd_wr_i,
   input  logic [31:0] wr_data_i,
   output logic [31:0] rd_data_o,
   output logic        mem_ready_o,
   input  logic        load_valid_i,
   output logic        load_ready_o,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_data_i,
   output logic        err_o,
   output logic [15:0] st_count_o
);

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam logic [31:0] SPAN_BYTES = 32'(DEPTH * WORD_BYTES);
   localparam mem_state_t  RESET_ST   = CLEAR_INIT ? CLEAR : SERVE;

   mem_state_t  state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic        err_q, err_d;
   logic [15:0] st_count_q, st_count_d;

   // Unsigned offset wraps below BASE_ADDR, so one compare covers both range bounds.
   logic [31:0] cpu_off, load_off;
   logic        cpu_in_range, load_in_range;
   logic        cpu_aligned, load_aligned;

   assign cpu_off       = addr_i - BASE_ADDR;
   assign load_off      = load_addr_i - BASE_ADDR;
   assign cpu_in_range  = cpu_off < SPAN_BYTES;
   assign load_in_range = load_off < SPAN_BYTES;
   assign cpu_aligned   = cpu_off[1:0] == 2'b00;
   assign load_aligned  = load_off[1:0] == 2'b00;

   logic          serve;
   logic          cpu_write, cpu_store_ok, load_accept, load_write;
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic          rd_en, rd_zero;

   assign serve        = state_q == SERVE;
   assign cpu_write    = serve && (data_rd_wr_i == MEM_WRITE);
   assign cpu_store_ok = cpu_write && cpu_in_range && cpu_aligned;
   assign load_ready_o = serve && (data_rd_wr_i == MEM_READ);
   assign load_accept  = load_valid_i && load_ready_o;
   assign load_write   = load_accept && load_in_range && load_aligned;

   // Single write port priority: clear sweep, then CPU store, then backdoor load.
   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      if (!serve) begin
         we    = 1'b1;
         waddr = clr_cnt_q;
      end else if (cpu_store_ok) begin
         we    = 1'b1;
         waddr = cpu_off[AW+1:2];
         wdata = wr_data_i;
      end else if (load_write) begin
         we    = 1'b1;
         waddr = load_off[AW+1:2];
         wdata = load_data_i;
      end
   end

   // Read data is forced to zero during clear and for stray reads; held across CPU stores.
   always_comb begin
      rd_en   = 1'b1;
      rd_zero = 1'b1;
      if (serve) begin
         rd_en   = data_rd_wr_i == MEM_READ;
         rd_zero = !cpu_in_range;
      end
   end

   // Clear-sweep FSM next state.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_d = SERVE;
         end
      end
   end

   // Sticky illegal-store flag and saturating committed-store counter.
   always_comb begin
      err_d      = err_q;
      st_count_d = st_count_q;
      if (cpu_write && !cpu_store_ok) begin
         err_d = 1'b1;
      end
      if (cpu_store_ok && st_count_q != 16'hFFFF) begin
         st_count_d = st_count_q + 16'd1;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= RESET_ST;
         clr_cnt_q  <= '0;
         err_q      <= 1'b0;
         st_count_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         err_q      <= err_d;
         st_count_q <= st_count_d;
      end
   end

   dmem_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .we_i     (we),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
      .rd_en_i  (rd_en),
      .rd_zero_i(rd_zero),
      .raddr_i  (cpu_off[AW+1:2]),
      .rd_data_o(rd_data_o)
   );

   assign mem_ready_o = serve;
   assign err_o       = err_q;
   assign st_count_o  = st_count_q;

endmodule
